// File: rtl/morse_pkg.sv
// Shared definitions for the Morse relay game: state codes, default sizing and symbol encoding.
package morse_pkg;

    localparam int unsigned ADDR_W_DEF  = 4;
    localparam int unsigned SCORE_W_DEF = 4;
    localparam int          TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_P1TURN = 3'd1,
        S_P2TURN = 3'd2,
        S_RESULT = 3'd3
    } state_t;

    // 2-bit symbol stored in the message RAM, shared with player2 and the translator
    typedef enum logic [1:0] {
        SYM_NONE = 2'd0,
        SYM_DOT  = 2'd1,
        SYM_DASH = 2'd2,
        SYM_GAP  = 2'd3
    } symbol_t;

endpackage

// File: rtl/btn_press_det.sv
// Falling-edge press detector for an active-low push button; one event per press however long it is held.
module btn_press_det (
    input  logic clock_1hz,
    input  logic resetn,
    input  logic btn_n,
    output logic press_c
);

    logic hist_q;

    // history resets to "released" so a button held through reset yields a press afterwards
    always_ff @(posedge clock_1hz) begin
        if (!resetn) hist_q <= 1'b1;
        else         hist_q <= btn_n;
    end

    assign press_c = hist_q & ~btn_n;

endmodule

// File: rtl/morse_round_ctrl.sv
// Round controller for the Morse relay game: START / P1 record / P2 replay / RESULT sequencing and scoring.
// Optional P2 idle timeout enabled by defining MORSE_TIMEOUT_EN.
module morse_round_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned SCORE_W = SCORE_W_DEF,
    parameter int          TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock_1hz,
    input  logic               resetn,
    input  logic               next_n,
    input  logic               done_n,
    input  logic               p2_correct,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_wren,
    output logic               ram_strobe,
    output logic [2:0]         state,
    output logic [ADDR_W:0]    p1_len,
    output logic [ADDR_W:0]    p2_idx,
    output logic               overflow,
    output logic               win,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned      LEN_W     = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH     = LEN_W'(1) << ADDR_W;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    if (TIMEOUT <= 0) begin : g_bad_timeout
        $error("morse_round_ctrl: TIMEOUT must be positive");
    end

    logic next_press_c, done_press_c;

    btn_press_det u_next_det (
        .clock_1hz (clock_1hz),
        .resetn    (resetn),
        .btn_n     (next_n),
        .press_c   (next_press_c)
    );

    btn_press_det u_done_det (
        .clock_1hz (clock_1hz),
        .resetn    (resetn),
        .btn_n     (done_n),
        .press_c   (done_press_c)
    );

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wren_q, wren_d;
    logic               strobe_q, strobe_d;
    logic [LEN_W-1:0]   p1_len_q, p1_len_d;
    logic [LEN_W-1:0]   p2_idx_q, p2_idx_d;
    logic               ovf_q, ovf_d;
    logic               win_q, win_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               mismatch_q, mismatch_d;
    logic               enter_result, result_win, mm_next;
    logic [LEN_W-1:0]   idx_inc;

`ifdef MORSE_TIMEOUT_EN
    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    // next-state and datapath; done always beats next in the same cycle
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        strobe_d     = 1'b0;
        p1_len_d     = p1_len_q;
        p2_idx_d     = p2_idx_q;
        ovf_d        = ovf_q;
        win_d        = win_q;
        score_d      = score_q;
        mismatch_d   = mismatch_q;
        enter_result = 1'b0;
        result_win   = 1'b0;
        idx_inc      = p2_idx_q + LEN_W'(1);
        mm_next      = mismatch_q | ~p2_correct;
`ifdef MORSE_TIMEOUT_EN
        idle_d       = '0;
`endif
        case (state_q)
            S_START: begin
                if (done_press_c) begin
                    state_d    = S_P1TURN;
                    p1_len_d   = '0;
                    p2_idx_d   = '0;
                    ovf_d      = 1'b0;
                    win_d      = 1'b0;
                    mismatch_d = 1'b0;
                end
            end
            S_P1TURN: begin
                if (done_press_c) begin
                    if (p1_len_q != '0) state_d = S_P2TURN;
                end else if (next_press_c) begin
                    if (p1_len_q < DEPTH) begin
                        strobe_d = 1'b1;
                        addr_d   = p1_len_q[ADDR_W-1:0];
                        p1_len_d = p1_len_q + LEN_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_P2TURN: begin
                if (done_press_c) begin
                    enter_result = 1'b1;
                    result_win   = ~mismatch_q & (p2_idx_q == p1_len_q);
                end else if (next_press_c) begin
                    strobe_d   = 1'b1;
                    addr_d     = p2_idx_q[ADDR_W-1:0];
                    p2_idx_d   = idx_inc;
                    mismatch_d = mm_next;
                    if (idx_inc == p1_len_q) begin
                        enter_result = 1'b1;
                        result_win   = ~mm_next;
                    end
                end
`ifdef MORSE_TIMEOUT_EN
                else if (idle_q == IDLE_LAST) begin
                    enter_result = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
`endif
            end
            S_RESULT: begin
                if (done_press_c) state_d = S_START;
            end
            default: state_d = S_START;
        endcase

        if (enter_result) begin
            state_d = S_RESULT;
            win_d   = result_win;
            if (result_win && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
        end
        wren_d = (state_d == S_P1TURN);
    end

    always_ff @(posedge clock_1hz) begin
        if (!resetn) begin
            state_q    <= S_START;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            strobe_q   <= 1'b0;
            p1_len_q   <= '0;
            p2_idx_q   <= '0;
            ovf_q      <= 1'b0;
            win_q      <= 1'b0;
            score_q    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wren_q     <= wren_d;
            strobe_q   <= strobe_d;
            p1_len_q   <= p1_len_d;
            p2_idx_q   <= p2_idx_d;
            ovf_q      <= ovf_d;
            win_q      <= win_d;
            score_q    <= score_d;
            mismatch_q <= mismatch_d;
        end
    end

`ifdef MORSE_TIMEOUT_EN
    always_ff @(posedge clock_1hz) begin
        if (!resetn) idle_q <= '0;
        else         idle_q <= idle_d;
    end
`endif

    assign ram_addr   = addr_q;
    assign ram_wren   = wren_q;
    assign ram_strobe = strobe_q;
    assign state      = state_q;
    assign p1_len     = p1_len_q;
    assign p2_idx     = p2_idx_q;
    assign overflow   = ovf_q;
    assign win        = win_q;
    assign score      = score_q;

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Self-checking bench for morse_round_ctrl: directed round scenarios plus randomized play against a game model.
module tb_morse_round_ctrl;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned SCORE_W = 2;
    localparam int          TIMEOUT = 3;
    localparam int          DEPTH   = 4;
    localparam int          SMAX    = 3;

    logic               clock_1hz = 1'b0;
    logic               resetn = 1'b0;
    logic               next_n = 1'b1;
    logic               done_n = 1'b1;
    logic               p2_correct = 1'b1;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_wren, ram_strobe, overflow, win;
    logic [2:0]         state;
    logic [ADDR_W:0]    p1_len, p2_idx;
    logic [SCORE_W-1:0] score;

    int checks = 0;
    int errors = 0;

    // game model: phase 0=start 1=recording 2=replaying 3=result
    int m_phase, m_len, m_idx, m_score, m_addr, m_idle;
    bit m_ovf, m_win, m_bad, m_strobe, m_pn, m_pd;

    morse_round_ctrl #(.ADDR_W(ADDR_W), .SCORE_W(SCORE_W), .TIMEOUT(TIMEOUT)) dut (
        .clock_1hz (clock_1hz), .resetn (resetn), .next_n (next_n), .done_n (done_n),
        .p2_correct (p2_correct), .ram_addr (ram_addr), .ram_wren (ram_wren),
        .ram_strobe (ram_strobe), .state (state), .p1_len (p1_len), .p2_idx (p2_idx),
        .overflow (overflow), .win (win), .score (score)
    );

    always #5 clock_1hz = ~clock_1hz;

    task automatic model_judge();
        m_phase = 3;
        m_win   = !m_bad && (m_idx == m_len);
        if (m_win && m_score < SMAX) m_score++;
    endtask

    task automatic model_edge(input logic nn, input logic dn, input logic pc);
        bit ne, de;
        if (!resetn) begin
            m_phase = 0; m_len = 0; m_idx = 0; m_score = 0; m_addr = 0; m_idle = 0;
            m_ovf = 0; m_win = 0; m_bad = 0; m_strobe = 0; m_pn = 1; m_pd = 1;
            return;
        end
        ne = m_pn && !nn;
        de = m_pd && !dn;
        m_pn = nn;
        m_pd = dn;
        m_strobe = 0;
        case (m_phase)
            0: if (de) begin
                m_phase = 1; m_len = 0; m_idx = 0; m_ovf = 0; m_win = 0; m_bad = 0;
            end
            1: if (de) begin
                if (m_len > 0) begin m_phase = 2; m_idle = 0; end
            end else if (ne) begin
                if (m_len < DEPTH) begin m_strobe = 1; m_addr = m_len; m_len++; end
                else m_ovf = 1;
            end
            2: if (de) model_judge();
            else if (ne) begin
                m_strobe = 1; m_addr = m_idx; m_idx++; m_idle = 0;
                m_bad = m_bad | !pc;
                if (m_idx == m_len) model_judge();
            end else begin
                m_idle++;
`ifdef MORSE_TIMEOUT_EN
                if (m_idle >= TIMEOUT) begin m_phase = 3; m_win = 0; end
`endif
            end
            default: if (de) m_phase = 0;
        endcase
    endtask

    // drive levels for the coming edge, advance the model, sample 1 time unit after the edge
    task automatic step(input logic nn, input logic dn, input logic pc);
        next_n = nn; done_n = dn; p2_correct = pc;
        model_edge(nn, dn, pc);
        @(posedge clock_1hz);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1, 1, 1);
        step(1, 1, 1);
        resetn = 1'b1;
    endtask

    task automatic press_done();
        step(1, 0, 1);
        step(1, 1, 1);
    endtask

    task automatic enter_p2(input int n);
        press_done();
        for (int i = 0; i < n; i++) begin step(0, 1, 1); step(1, 1, 1); end
        press_done();
    endtask

    task automatic replay(input int n, input logic [7:0] ok);
        for (int i = 0; i < n; i++) begin step(0, 1, ok[i]); step(1, 1, ok[i]); end
    endtask

    task automatic test_reset();
        step(0, 0, 0);
        do_reset();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (p1_len !== 3'd0) begin errors++; $display("FAIL reset_p1_len: got %0d expected 0", p1_len); end
        checks++; if (p2_idx !== 3'd0) begin errors++; $display("FAIL reset_p2_idx: got %0d expected 0", p2_idx); end
        checks++; if (score !== 2'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
        checks++; if ({overflow, win, ram_strobe, ram_wren} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {overflow, win, ram_strobe, ram_wren}); end
        checks++; if (ram_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
    endtask

    task automatic test_win_round();
        do_reset();
        press_done();
        checks++; if (state !== 3'd1 || ram_wren !== 1'b1) begin errors++; $display("FAIL win_p1_entry: got state %0d wren %b expected 1 1", state, ram_wren); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1);
            checks++; if (ram_strobe !== 1'b1 || ram_addr !== 2'(i) || ram_wren !== 1'b1) begin errors++; $display("FAIL win_write%0d: got strobe %b addr %0d wren %b expected 1 %0d 1", i, ram_strobe, ram_addr, ram_wren, i); end
            step(1, 1, 1);
            checks++; if (ram_strobe !== 1'b0) begin errors++; $display("FAIL win_write_pulse%0d: got %b expected 0", i, ram_strobe); end
        end
        checks++; if (p1_len !== 3'd3) begin errors++; $display("FAIL win_p1_len: got %0d expected 3", p1_len); end
        press_done();
        checks++; if (state !== 3'd2 || ram_wren !== 1'b0) begin errors++; $display("FAIL win_p2_entry: got state %0d wren %b expected 2 0", state, ram_wren); end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1);
            checks++; if (ram_strobe !== 1'b1 || ram_addr !== 2'(i) || ram_wren !== 1'b0) begin errors++; $display("FAIL win_read%0d: got strobe %b addr %0d wren %b expected 1 %0d 0", i, ram_strobe, ram_addr, ram_wren, i); end
            step(1, 1, 1);
        end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL win_state: got %0d expected 3", state); end
        checks++; if (win !== 1'b1 || score !== 2'd1) begin errors++; $display("FAIL win_result: got win %b score %0d expected 1 1", win, score); end
        checks++; if (p2_idx !== 3'd3) begin errors++; $display("FAIL win_p2_idx: got %0d expected 3", p2_idx); end
        press_done();
        checks++; if (state !== 3'd0 || score !== 2'd1) begin errors++; $display("FAIL win_back_start: got state %0d score %0d expected 0 1", state, score); end
    endtask

    task automatic test_lose_round();
        do_reset();
        enter_p2(3);
        replay(3, 8'b101);
        checks++; if (state !== 3'd3 || win !== 1'b0 || score !== 2'd0) begin errors++; $display("FAIL lose_result: got state %0d win %b score %0d expected 3 0 0", state, win, score); end
    endtask

    task automatic test_overflow();
        do_reset();
        press_done();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
            step(0, 1, 1);
            if (i < 4) begin
                checks++; if (ram_strobe !== 1'b1 || ram_addr !== 2'(i)) begin errors++; $display("FAIL ovf_write%0d: got strobe %b addr %0d expected 1 %0d", i, ram_strobe, ram_addr, i); end
            end else begin
                checks++; if (ram_strobe !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_fifth: got strobe %b overflow %b expected 0 1", ram_strobe, overflow); end
            end
            step(1, 1, 1);
        end
        checks++; if (p1_len !== 3'd4 || state !== 3'd1) begin errors++; $display("FAIL ovf_len: got len %0d state %0d expected 4 1", p1_len, state); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_done();
        for (int i = 0; i < 2; i++) begin step(0, 1, 1); step(1, 1, 1); end
        step(0, 0, 1);
        checks++; if (state !== 3'd2 || ram_strobe !== 1'b0 || p1_len !== 3'd2) begin errors++; $display("FAIL simul: got state %0d strobe %b len %0d expected 2 0 2", state, ram_strobe, p1_len); end
        step(1, 1, 1);
    endtask

    task automatic test_done_empty_and_hold();
        int strobes;
        do_reset();
        press_done();
        press_done();
        checks++; if (state !== 3'd1 || p1_len !== 3'd0) begin errors++; $display("FAIL done_empty: got state %0d len %0d expected 1 0", state, p1_len); end
        strobes = 0;
        for (int i = 0; i < 5; i++) begin step(0, 1, 1); strobes += int'(ram_strobe); end
        step(1, 1, 1); strobes += int'(ram_strobe);
        checks++; if (strobes != 1 || p1_len !== 3'd1) begin errors++; $display("FAIL hold: got strobes %0d len %0d expected 1 1", strobes, p1_len); end
    endtask

    task automatic test_early_done();
        do_reset();
        enter_p2(3);
        replay(1, 8'h01);
        step(1, 0, 1);
        checks++; if (state !== 3'd3 || win !== 1'b0 || p2_idx !== 3'd1) begin errors++; $display("FAIL early_done: got state %0d win %b idx %0d expected 3 0 1", state, win, p2_idx); end
        step(1, 1, 1);
    endtask

    task automatic test_reset_mid_p2();
        do_reset();
        enter_p2(2);
        replay(2, 8'hFF);
        checks++; if (score !== 2'd1) begin errors++; $display("FAIL midrst_pre_score: got %0d expected 1", score); end
        press_done();
        enter_p2(3);
        replay(1, 8'hFF);
        resetn = 1'b0;
        step(1, 1, 1);
        checks++; if (state !== 3'd0 || score !== 2'd0 || p2_idx !== 3'd0 || p1_len !== 3'd0) begin errors++; $display("FAIL midrst: got state %0d score %0d idx %0d len %0d expected 0 0 0 0", state, score, p2_idx, p1_len); end
        resetn = 1'b1;
    endtask

    task automatic test_score_sat();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            enter_p2(1);
            replay(1, 8'h01);
            checks++; if (score !== 2'((r + 1 > SMAX) ? SMAX : r + 1)) begin errors++; $display("FAIL score_sat%0d: got %0d expected %0d", r, score, (r + 1 > SMAX) ? SMAX : r + 1); end
            press_done();
        end
    endtask

    task automatic test_p2_idle();
        do_reset();
        press_done();
        for (int i = 0; i < 2; i++) begin step(0, 1, 1); step(1, 1, 1); end
        step(1, 0, 1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL idle_entry: got %0d expected 2", state); end
`ifdef MORSE_TIMEOUT_EN
        step(1, 1, 1); step(1, 1, 1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL timeout_early: got %0d expected 2", state); end
        step(1, 1, 1);
        checks++; if (state !== 3'd3 || win !== 1'b0 || score !== 2'd0) begin errors++; $display("FAIL timeout: got state %0d win %b score %0d expected 3 0 0", state, win, score); end
`else
        for (int i = 0; i < 10; i++) step(1, 1, 1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL idle_wait: got %0d expected 2", state); end
`endif
    endtask

    task automatic test_random();
        logic nn, dn, pc;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            nn = ($urandom_range(0, 2) != 0);
            dn = ($urandom_range(0, 9) != 0);
            pc = ($urandom_range(0, 7) != 0);
            step(nn, dn, pc);
            checks++; if (state !== 3'(m_phase)) begin errors++; $display("FAIL rnd_state@%0d: got %0d expected %0d", i, state, m_phase); end
            checks++; if (p1_len !== 3'(m_len) || p2_idx !== 3'(m_idx)) begin errors++; $display("FAIL rnd_ptr@%0d: got len %0d idx %0d expected %0d %0d", i, p1_len, p2_idx, m_len, m_idx); end
            checks++; if (ram_strobe !== m_strobe || ram_addr !== 2'(m_addr) || ram_wren !== (m_phase == 1)) begin errors++; $display("FAIL rnd_ram@%0d: got strobe %b addr %0d wren %b expected %b %0d %b", i, ram_strobe, ram_addr, ram_wren, m_strobe, m_addr, m_phase == 1); end
            checks++; if (overflow !== m_ovf || win !== m_win || score !== 2'(m_score)) begin errors++; $display("FAIL rnd_result@%0d: got ovf %b win %b score %0d expected %b %b %0d", i, overflow, win, score, m_ovf, m_win, m_score); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_win_round();
        test_lose_round();
        test_overflow();
        test_simultaneous();
        test_done_empty_and_hold();
        test_early_done();
        test_reset_mid_p2();
        test_score_sat();
        test_p2_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
